// File: rtl/ex_stage.sv
// Execute stage: registers the decode bus and computes the ALU result. Owns the
// HI/LO registers, which are fed by a single-cycle multiplier and a 32-step restoring divider.
module ex_stage (
   input  logic         clk,
   input  logic         rst,
   input  logic [5:0]   stall,
   input  logic [158:0] id_to_ex_bus,
   output logic [75:0]  ex_to_mem_bus,
   output logic [37:0]  ex_to_rf_bus,
   output logic         data_sram_en,
   output logic [3:0]   data_sram_wen,
   output logic [31:0]  data_sram_addr,
   output logic [31:0]  data_sram_wdata,
   output logic         stallreq_for_ex
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [158:0] bus_q, bus_d;

   always_comb begin
      bus_d = bus_q;
      if (stall[2] && !stall[3]) bus_d = '0;
      else if (!stall[2])        bus_d = id_to_ex_bus;
   end

   always_ff @(posedge clk) begin
      if (rst) bus_q <= '0;
      else     bus_q <= bus_d;
   end

   logic [31:0] pc, inst, rdata1, rdata2;
   logic [11:0] alu_op;
   logic [2:0]  sel_src1;
   logic [3:0]  sel_src2, ram_wen;
   logic        ram_en, rf_we, sel_rf_res;
   logic [4:0]  rf_waddr;

   assign {pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen, rf_we, rf_waddr,
           sel_rf_res, rdata1, rdata2} = bus_q;

   logic is_rtype, is_mult, is_multu, is_div, is_divu;
   logic is_mfhi, is_mflo, is_mthi, is_mtlo;

   assign is_rtype = (inst[31:26] == 6'd0);
   assign is_mult  = is_rtype && (inst[5:0] == 6'h18);
   assign is_multu = is_rtype && (inst[5:0] == 6'h19);
   assign is_div   = is_rtype && (inst[5:0] == 6'h1a);
   assign is_divu  = is_rtype && (inst[5:0] == 6'h1b);
   assign is_mfhi  = is_rtype && (inst[5:0] == 6'h10);
   assign is_mthi  = is_rtype && (inst[5:0] == 6'h11);
   assign is_mflo  = is_rtype && (inst[5:0] == 6'h12);
   assign is_mtlo  = is_rtype && (inst[5:0] == 6'h13);

   logic [31:0] src1, src2;

   always_comb begin
      src1 = '0;
      if (sel_src1[0]) src1 = src1 | rdata1;
      if (sel_src1[1]) src1 = src1 | pc;
      if (sel_src1[2]) src1 = src1 | {27'd0, inst[10:6]};
      src2 = '0;
      if (sel_src2[0]) src2 = src2 | rdata2;
      if (sel_src2[1]) src2 = src2 | {{16{inst[15]}}, inst[15:0]};
      if (sel_src2[2]) src2 = src2 | 32'd8;
      if (sel_src2[3]) src2 = src2 | {16'd0, inst[15:0]};
   end

   // Kept as its own net so the arithmetic shift is not turned unsigned by the OR below
   logic [31:0] sra_res, alu_res;
   assign sra_res = $signed(src2) >>> src1[4:0];

   always_comb begin
      alu_res = '0;
      if (alu_op[11]) alu_res = alu_res | (src1 + src2);
      if (alu_op[10]) alu_res = alu_res | (src1 - src2);
      if (alu_op[9])  alu_res = alu_res | {31'd0, $signed(src1) < $signed(src2)};
      if (alu_op[8])  alu_res = alu_res | {31'd0, src1 < src2};
      if (alu_op[7])  alu_res = alu_res | (src1 & src2);
      if (alu_op[6])  alu_res = alu_res | ~(src1 | src2);
      if (alu_op[5])  alu_res = alu_res | (src1 | src2);
      if (alu_op[4])  alu_res = alu_res | (src1 ^ src2);
      if (alu_op[3])  alu_res = alu_res | (src2 << src1[4:0]);
      if (alu_op[2])  alu_res = alu_res | (src2 >> src1[4:0]);
      if (alu_op[1])  alu_res = alu_res | sra_res;
      if (alu_op[0])  alu_res = alu_res | {src2[15:0], 16'd0};
   end

   // Low 64 bits of the product of sign-extended operands equal the signed product
   logic [63:0] mul_a, mul_b, product;
   assign mul_a   = {{32{is_mult & rdata1[31]}}, rdata1};
   assign mul_b   = {{32{is_mult & rdata2[31]}}, rdata2};
   assign product = mul_a * mul_b;

   logic [1:0]  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] quo_q, quo_d, rem_q, rem_d, dsor_q, dsor_d;
   logic        q_neg_q, q_neg_d, r_neg_q, r_neg_d;
   logic [32:0] shifted;
   logic [33:0] diff;
   logic [31:0] dvd_abs, dsor_abs, div_q, div_r;

   assign dvd_abs  = (is_div && rdata1[31]) ? 32'd0 - rdata1 : rdata1;
   assign dsor_abs = (is_div && rdata2[31]) ? 32'd0 - rdata2 : rdata2;
   assign shifted  = {rem_q, quo_q[31]};
   assign diff     = {1'b0, shifted} - {2'b00, dsor_q};
   assign div_q    = q_neg_q ? 32'd0 - quo_q : quo_q;
   assign div_r    = r_neg_q ? 32'd0 - rem_q : rem_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dsor_d  = dsor_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      case (state_q)
         S_IDLE: if (is_div || is_divu) begin
            quo_d   = dvd_abs;
            rem_d   = '0;
            dsor_d  = dsor_abs;
            cnt_d   = '0;
            q_neg_d = is_div && (rdata1[31] ^ rdata2[31]);
            r_neg_d = is_div && rdata1[31];
            state_d = S_BUSY;
         end
         S_BUSY: begin
            if (!diff[33]) begin
               rem_d = diff[31:0];
               quo_d = {quo_q[30:0], 1'b1};
            end else begin
               rem_d = shifted[31:0];
               quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = S_DONE;
         end
         // Leave DONE whenever the divide leaves EX, committed or bubbled away
         S_DONE: if (!(stall[2] && stall[3])) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   logic [31:0] hi_q, hi_d, lo_q, lo_d;

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (!stall[2]) begin
         if (state_q == S_DONE)        {hi_d, lo_d} = {div_r, div_q};
         else if (is_mult || is_multu) {hi_d, lo_d} = product;
         else if (is_mthi)             hi_d = rdata1;
         else if (is_mtlo)             lo_d = rdata1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dsor_q  <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dsor_q  <= dsor_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   logic [31:0] ex_result;
   logic        rf_we_eff;
   logic [4:0]  rf_waddr_eff;

   assign ex_result    = is_mfhi ? hi_q : (is_mflo ? lo_q : alu_res);
   assign rf_we_eff    = rf_we | is_mfhi | is_mflo;
   assign rf_waddr_eff = (is_mfhi || is_mflo) ? inst[15:11] : rf_waddr;

   assign ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, rf_we_eff, rf_waddr_eff, ex_result};
   assign ex_to_rf_bus    = {rf_we_eff, rf_waddr_eff, ex_result};
   assign data_sram_en    = ram_en;
   assign data_sram_wen   = ram_wen;
   assign data_sram_addr  = ex_result;
   assign data_sram_wdata = rdata2;
   assign stallreq_for_ex = (is_div || is_divu) && (state_q != S_DONE);

   logic unused_bits;
   assign unused_bits = ^{stall[5:4], stall[1:0], inst[25:16], diff[32]};

endmodule

// File: tb/tb_ex_stage.sv
// Randomized scoreboard bench for ex_stage: a driver models the stage at
// instruction level and queues expected outputs; a monitor compares them per cycle.
module tb_ex_stage;

   logic         clk = 1'b0;
   logic         rst;
   logic [5:0]   stall;
   logic [158:0] id_to_ex_bus;
   logic [75:0]  ex_to_mem_bus;
   logic [37:0]  ex_to_rf_bus;
   logic         data_sram_en;
   logic [3:0]   data_sram_wen;
   logic [31:0]  data_sram_addr, data_sram_wdata;
   logic         stallreq_for_ex;

   ex_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_to_ex_bus),
      .ex_to_mem_bus(ex_to_mem_bus), .ex_to_rf_bus(ex_to_rf_bus),
      .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .stallreq_for_ex(stallreq_for_ex)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [75:0] mem;
      logic [31:0] wdata;
   } exp_t;

   exp_t scb[$];
   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   // Monitor: compare every queued expectation against the cycle it belongs to
   exp_t me;
   always @(negedge clk) begin
      while (scb.size() > 0 && scb[0].cyc <= cyc) begin
         me = scb.pop_front();
         if (me.cyc != cyc) check("scb_cycle", 128'(cyc), 128'(me.cyc));
         else begin
            check($sformatf("mem_bus@%0d", cyc), ex_to_mem_bus, me.mem);
            check($sformatf("rf_bus@%0d", cyc), ex_to_rf_bus, me.mem[37:0]);
            check($sformatf("sram_en@%0d", cyc), data_sram_en, me.mem[43]);
            check($sformatf("sram_wen@%0d", cyc), data_sram_wen, me.mem[42:39]);
            check($sformatf("sram_addr@%0d", cyc), data_sram_addr, me.mem[31:0]);
            check($sformatf("sram_wdata@%0d", cyc), data_sram_wdata, me.wdata);
         end
      end
   end

   // Reference model: architectural HI/LO plus a write waiting on its commit edge
   logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
   bit          p_vld = 0;

   typedef enum int {K_MULT, K_MULTU, K_MTHI, K_MTLO, K_MFHI, K_MFLO, K_DIV, K_DIVU} hl_t;

   function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
         input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2, input logic en,
         input logic [3:0] wen, input logic we, input logic [4:0] wa, input logic sr,
         input logic [31:0] r1, input logic [31:0] r2);
      return {pc, inst, op, s1, s2, en, wen, we, wa, sr, r1, r2};
   endfunction

   function automatic logic [31:0] alu_ref(input int k, input logic [31:0] a, input logic [31:0] b);
      int sa = a;
      int sb = b;
      case (k)
         0:  return a + b;
         1:  return a - b;
         2:  return (sa < sb) ? 32'd1 : 32'd0;
         3:  return (a < b) ? 32'd1 : 32'd0;
         4:  return a & b;
         5:  return ~(a | b);
         6:  return a | b;
         7:  return a ^ b;
         8:  return b << a[4:0];
         9:  return b >> a[4:0];
         10: return sb >>> a[4:0];
         11: return {b[15:0], 16'd0};
         default: return 32'd0;
      endcase
   endfunction

   task automatic pre(input logic [5:0] st);
      if (!st[2] && p_vld) begin
         m_hi = p_hi;
         m_lo = p_lo;
      end
      p_vld = 0;
   endtask

   task automatic drive(input logic [158:0] bus, input logic [5:0] st, input exp_t e);
      exp_t x = e;
      id_to_ex_bus = bus;
      stall = st;
      @(posedge clk); #1;
      x.cyc = cyc;
      scb.push_back(x);
   endtask

   task automatic issue_alu(input int k, input int s1i, input int s2i, input logic [31:0] pc,
         input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2, input logic en,
         input logic [3:0] wen, input logic we, input logic [4:0] wa, input logic sr);
      logic [31:0] a, b, res;
      logic [11:0] op;
      exp_t e;
      pre(6'd0);
      a = (s1i == 0) ? r1 : (s1i == 1) ? pc : {27'd0, inst[10:6]};
      case (s2i)
         0:       b = r2;
         1:       b = {{16{inst[15]}}, inst[15:0]};
         2:       b = 32'd8;
         default: b = {16'd0, inst[15:0]};
      endcase
      op  = (k < 12) ? (12'h800 >> k) : 12'd0;
      res = alu_ref(k, a, b);
      e.cyc = 0;
      e.mem = {pc, en, wen, sr, we, wa, res};
      e.wdata = r2;
      drive(mk(pc, inst, op, 3'(1 << s1i), 4'(1 << s2i), en, wen, we, wa, sr, r1, r2), 6'd0, e);
   endtask

   task automatic issue_hl(input hl_t kind, input logic [31:0] r1, input logic [31:0] r2,
         input logic [4:0] rd, input bit run_div);
      logic [5:0]  funct;
      logic [31:0] inst, pc, res, q, r;
      logic        we;
      logic [4:0]  wa;
      longint      la, lb, sp;
      longint unsigned ua, ub;
      exp_t e;
      int n;
      case (kind)
         K_MULT:  funct = 6'h18;
         K_MULTU: funct = 6'h19;
         K_DIV:   funct = 6'h1a;
         K_DIVU:  funct = 6'h1b;
         K_MFHI:  funct = 6'h10;
         K_MTHI:  funct = 6'h11;
         K_MFLO:  funct = 6'h12;
         default: funct = 6'h13;
      endcase
      inst = {6'd0, 5'($urandom), 5'($urandom), rd, 5'd0, funct};
      pc   = $urandom;
      we   = 1'($urandom);
      wa   = 5'($urandom);
      pre(6'd0);
      res = 0;
      case (kind)
         K_MFHI: begin res = m_hi; we = 1; wa = rd; end
         K_MFLO: begin res = m_lo; we = 1; wa = rd; end
         K_MULT: begin
            la = longint'(int'(r1)); lb = longint'(int'(r2)); sp = la * lb;
            {p_hi, p_lo} = sp; p_vld = 1;
         end
         K_MULTU: begin
            ua = r1; ub = r2;
            {p_hi, p_lo} = ua * ub; p_vld = 1;
         end
         K_MTHI: begin p_hi = r1; p_lo = m_lo; p_vld = 1; end
         K_MTLO: begin p_hi = m_hi; p_lo = r1; p_vld = 1; end
         K_DIVU: begin
            if (r2 == 0) begin q = 32'hFFFF_FFFF; r = r1; end
            else begin q = r1 / r2; r = r1 % r2; end
            p_hi = r; p_lo = q; p_vld = 1;
         end
         default: begin
            if (r2 == 0) begin
               q = 32'hFFFF_FFFF;
               r = r1[31] ? -r1 : r1;
               if (r1[31]) begin q = -q; r = -r; end
            end else begin
               la = longint'(int'(r1)); lb = longint'(int'(r2));
               q = 32'(la / lb); r = 32'(la % lb);
            end
            p_hi = r; p_lo = q; p_vld = 1;
         end
      endcase
      e.cyc = 0;
      e.mem = {pc, 1'b0, 4'd0, 1'b0, we, wa, res};
      e.wdata = r2;
      drive(mk(pc, inst, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, we, 5'(wa), 1'b0, r1, r2), 6'd0, e);
      if ((kind == K_DIV || kind == K_DIVU) && run_div) begin
         n = 0;
         while (stallreq_for_ex && n < 40) begin
            n++;
            stall = 6'b001111;
            @(posedge clk); #1;
            e.cyc = cyc;
            scb.push_back(e);
         end
         check("div_stall_cycles", 128'(n), 128'(33));
      end
   endtask

   task automatic issue_bubble();
      exp_t e;
      pre(6'b000100);
      e.cyc = 0;
      e.mem = '0;
      e.wdata = '0;
      drive({$urandom, $urandom, $urandom, $urandom, $urandom, 31'($urandom)}, 6'b000100, e);
   endtask

   task automatic rand_alu();
      issue_alu($urandom_range(0, 12), $urandom_range(0, 2), $urandom_range(0, 3), $urandom,
                {6'($urandom_range(1, 63)), 26'($urandom)}, $urandom, $urandom, 1'($urandom),
                4'($urandom), 1'($urandom), 5'($urandom), 1'($urandom));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sel;
      logic [31:0] dv;
      rst = 1;
      stall = 0;
      id_to_ex_bus = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_mem_bus", ex_to_mem_bus, 76'd0);
      check("reset_rf_bus", ex_to_rf_bus, 38'd0);
      check("reset_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, 69'd0);
      check("reset_stallreq", stallreq_for_ex, 1'b0);
      rst = 0;

      // addiu r2 = 0x7FFFFFFF + 1
      issue_alu(0, 0, 1, 32'h0040_0000, {6'h09, 5'd1, 5'd2, 16'h0001}, 32'h7FFF_FFFF, 32'd0,
                1'b0, 4'd0, 1'b1, 5'd2, 1'b0);
      // sw 0xDEADBEEF to 0x1000 - 4
      issue_alu(0, 0, 1, 32'h0040_0004, {6'h2b, 5'd1, 5'd2, 16'hFFFC}, 32'h0000_1000,
                32'hDEAD_BEEF, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0);
      issue_hl(K_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, 1);
      issue_hl(K_MFLO, 0, 0, 5'd3, 0);
      issue_hl(K_MFHI, 0, 0, 5'd4, 0);
      issue_hl(K_DIVU, 32'd7, 32'd0, 5'd0, 1);
      issue_hl(K_MFLO, 0, 0, 5'd5, 0);
      issue_hl(K_MFHI, 0, 0, 5'd6, 0);
      issue_hl(K_MULT, 32'hFFFF_FFFF, 32'd2, 5'd0, 0);
      issue_hl(K_MFHI, 0, 0, 5'd7, 0);
      issue_hl(K_MFLO, 0, 0, 5'd8, 0);
      issue_bubble();
      issue_alu(11, 0, 3, 32'h0040_0010, {6'h0f, 5'd0, 5'd9, 16'h1234}, 0, 0, 1'b0, 4'd0,
                1'b1, 5'd9, 1'b0);

      // Reset in the tenth busy cycle of a divide aborts it and clears HI/LO
      issue_hl(K_MTHI, 32'h1234_5678, 0, 5'd0, 0);
      issue_hl(K_MTLO, 32'h9ABC_DEF0, 0, 5'd0, 0);
      issue_hl(K_DIVU, 32'd100, 32'd7, 5'd0, 0);
      stall = 6'b001111;
      repeat (10) begin
         @(posedge clk); #1;
      end
      check("busy_before_rst", stallreq_for_ex, 1'b1);
      rst = 1;
      stall = 0;
      id_to_ex_bus = '0;
      @(posedge clk); #1;
      rst = 0;
      m_hi = 0; m_lo = 0; p_vld = 0;
      check("rst_mid_div_stallreq", stallreq_for_ex, 1'b0);
      check("rst_mid_div_mem_bus", ex_to_mem_bus, 76'd0);
      issue_hl(K_MFHI, 0, 0, 5'd10, 0);
      issue_hl(K_MFLO, 0, 0, 5'd11, 0);

      for (int i = 0; i < 300; i++) begin
         sel = $urandom_range(0, 99);
         if (sel < 55) rand_alu();
         else if (sel < 85) issue_hl(hl_t'($urandom_range(0, 5)), $urandom, $urandom, 5'($urandom), 0);
         else if (sel < 93) begin
            dv = (sel < 87) ? 32'd0 : ((sel < 90) ? 32'($urandom_range(1, 9)) : $urandom);
            if (sel == 91) dv = -dv;
            issue_hl((sel % 2 == 0) ? K_DIV : K_DIVU, $urandom, dv, 5'd0, 1);
         end else issue_bubble();
      end
      issue_hl(K_MFHI, 0, 0, 5'd1, 0);
      issue_hl(K_MFLO, 0, 0, 5'd2, 0);

      repeat (3) @(posedge clk);
      check("scoreboard_drained", 128'(scb.size()), 128'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
